// File: rtl/dram_word_writer_pkg.sv
// Shared geometry, len-code constants and push decode for the DRAM word writer.
package dram_word_writer_pkg;

   localparam int WIDTH  = 272;
   localparam int UNIT   = 16;
   localparam int UPW    = 17;
   localparam int ADDR_W = 24;
   localparam int DEPTH  = 2;

   // len codes count down as the push size grows; anything else pushes nothing
   localparam logic [3:0] LEN_1U = 4'd4;
   localparam logic [3:0] LEN_2U = 4'd3;
   localparam logic [3:0] LEN_3U = 4'd2;
   localparam logic [3:0] LEN_4U = 4'd1;

   function automatic logic [2:0] len_units(input logic [3:0] code);
      logic [2:0] units;
      units = '0;
      case (code)
         LEN_1U:  units = 3'd1;
         LEN_2U:  units = 3'd2;
         LEN_3U:  units = 3'd3;
         LEN_4U:  units = 3'd4;
         default: units = '0;
      endcase
      return units;
   endfunction

endpackage

// File: rtl/dram_word_writer_fifo.sv
// Small synchronous FIFO holding {address, word} entries; a push into a full
// FIFO is accepted when a pop happens on the same edge.
module word_fifo
   import dram_word_writer_pkg::*;
#(
   parameter int DEPTH = dram_word_writer_pkg::DEPTH,
   parameter int DW    = dram_word_writer_pkg::WIDTH + dram_word_writer_pkg::ADDR_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [DW-1:0] i_data,
   input  logic          i_pop,
   output logic [DW-1:0] o_head,
   output logic          o_full,
   output logic          o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW:0]   r_wptr;
   logic [AW:0]   r_rptr;
   logic          w_do_push;
   logic          w_do_pop;

   always_comb begin
      o_empty   = (r_wptr == r_rptr);
      o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
      w_do_pop  = i_pop && !o_empty;
      w_do_push = i_push && (!o_full || w_do_pop);
      o_head    = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/dram_word_writer.sv
// Tracks packer fill in units, captures each completed word with its DRAM address
// and presents it on a valid/ready write port; flags overshoot and dropped words.
module dram_word_writer
   import dram_word_writer_pkg::*;
#(
   parameter int WIDTH  = dram_word_writer_pkg::WIDTH,
   parameter int UNIT   = dram_word_writer_pkg::UNIT,
   parameter int UPW    = dram_word_writer_pkg::UPW,
   parameter int ADDR_W = dram_word_writer_pkg::ADDR_W,
   parameter int DEPTH  = dram_word_writer_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        len,
   input  logic [WIDTH-1:0]  pk_data,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [WIDTH-1:0]  wr_data,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [4:0]        fill,
   output logic              align_err,
   output logic              overflow
);

   if (WIDTH != UNIT * UPW) begin : g_bad_geometry
      $error("dram_word_writer: WIDTH must equal UNIT*UPW");
   end

   localparam logic [4:0] UPW_F = 5'(UPW);

   logic [4:0]              r_fill;
   logic [ADDR_W-1:0]       r_addr;
   logic                    r_align_err;
   logic                    r_overflow;

   logic [4:0]              w_fill_next;
   logic                    w_word_done;
   logic                    w_overshoot;
   logic                    w_pop;
   logic                    w_store;
   logic                    w_drop;
   logic                    w_full;
   logic                    w_empty;
   logic [ADDR_W+WIDTH-1:0] w_head;

   // pk_data lags the pushing edge by one cycle, so the word is taken at the
   // edge where the registered fill first shows completion
   always_comb begin
      w_word_done = (r_fill >= UPW_F);
      w_overshoot = (r_fill > UPW_F);
      w_pop       = !w_empty && wr_ready;
      w_store     = w_word_done && (!w_full || w_pop);
      w_drop      = w_word_done && w_full && !w_pop;
      w_fill_next = r_fill + {2'b00, len_units(len)} - (w_word_done ? UPW_F : 5'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fill      <= '0;
         r_addr      <= '0;
         r_align_err <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_fill <= w_fill_next;
         if (w_store)                    r_addr      <= r_addr + 1'b1;
         if (w_word_done && w_overshoot) r_align_err <= 1'b1;
         if (w_drop)                     r_overflow  <= 1'b1;
      end
   end

   word_fifo #(
      .DEPTH (DEPTH),
      .DW    (ADDR_W + WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_store),
      .i_data  ({r_addr, pk_data}),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_comb begin
      wr_valid  = !w_empty;
      wr_addr   = w_head[ADDR_W+WIDTH-1:WIDTH];
      wr_data   = w_head[WIDTH-1:0];
      fill      = r_fill;
      align_err = r_align_err;
      overflow  = r_overflow;
   end

endmodule

// File: tb/tb_dram_word_writer.sv
// Randomised and directed bench for dram_word_writer with a queue scoreboard and
// a unit-counting reference model of the packer/word stream.
module tb_dram_word_writer;

   localparam int TB_W   = 272;
   localparam int TB_AW  = 4;
   localparam int TB_UPW = 17;

   logic              clk = 1'b0;
   logic              rst;
   logic [3:0]        len;
   logic [TB_W-1:0]   pk_data;
   logic              wr_valid;
   logic              wr_ready;
   logic [TB_W-1:0]   wr_data;
   logic [TB_AW-1:0]  wr_addr;
   logic [4:0]        fill;
   logic              align_err;
   logic              overflow;

   always #5 clk = ~clk;

   dram_word_writer #(
      .WIDTH  (TB_W),
      .UNIT   (16),
      .UPW    (TB_UPW),
      .ADDR_W (TB_AW),
      .DEPTH  (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .len       (len),
      .pk_data   (pk_data),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
      .wr_addr   (wr_addr),
      .fill      (fill),
      .align_err (align_err),
      .overflow  (overflow)
   );

   typedef struct {
      logic [TB_AW-1:0] addr;
      logic [TB_W-1:0]  data;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;
   int m_fill   = 0;
   int m_occ    = 0;
   int m_addr   = 0;
   bit m_align  = 1'b0;
   bit m_ovf    = 1'b0;
   bit armed    = 1'b0;
   int n_deliv  = 0;
   logic [TB_AW-1:0] last_addr = '0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // word-level model: units accumulate, each completed word is stored if the
   // two-entry buffer has (or is making) room, otherwise it is counted as lost
   task automatic model(input logic [3:0] l, input bit rdy, input bit r, input logic [TB_W-1:0] pk);
      bit pop;
      if (r) begin
         m_fill = 0; m_occ = 0; m_addr = 0; m_align = 0; m_ovf = 0;
         sb.delete();
      end else begin
         pop = (m_occ > 0) && rdy;
         if (m_fill >= TB_UPW) begin
            if (m_fill > TB_UPW) m_align = 1'b1;
            if (m_occ < 2 || pop) begin
               sb.push_back('{addr: TB_AW'(m_addr), data: pk});
               m_addr = (m_addr + 1) % (1 << TB_AW);
               m_occ++;
            end else begin
               m_ovf = 1'b1;
            end
            m_fill -= TB_UPW;
         end
         if (pop) m_occ--;
         if (l >= 1 && l <= 4) m_fill += 5 - int'(l);
      end
   endtask

   task automatic step(input logic [3:0] l, input bit rdy, input bit r);
      logic [287:0] t;
      for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom();
      len      = l;
      wr_ready = rdy;
      rst      = r;
      pk_data  = t[TB_W-1:0];
      @(posedge clk);
      #1;
      model(l, rdy, r, t[TB_W-1:0]);
   endtask

   task automatic push_n(input logic [3:0] l, input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(l, rdy, 1'b0);
   endtask

   // monitor: compares the presented head word and status outputs every cycle
   always @(negedge clk) begin
      if (armed) begin
         chk("fill", fill, m_fill);
         chk("align_err", align_err, m_align);
         chk("overflow", overflow, m_ovf);
         chk("wr_valid", wr_valid, m_occ > 0);
         if (wr_valid) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_word: got addr %0h with no word expected", wr_addr);
            end else begin
               chk("wr_addr", wr_addr, sb[0].addr);
               chk("wr_data", wr_data, sb[0].data);
               if (wr_ready) begin
                  void'(sb.pop_front());
                  n_deliv++;
                  last_addr = wr_addr;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      rst = 1'b1; len = '0; wr_ready = 1'b0; pk_data = '0;
      step(4'd0, 1'b0, 1'b1);
      step(4'd0, 1'b0, 1'b1);
      armed = 1'b1;
      chk("rst_fill", fill, 0);
      chk("rst_valid", wr_valid, 0);
      chk("rst_addr", wr_addr, 0);
      chk("rst_data", wr_data, 0);

      // 17 single-unit pushes: word appears one cycle after completion
      d0 = n_deliv;
      push_n(4'd4, 17, 1'b1);
      chk("t1_fill17", fill, 17);
      chk("t1_not_yet_valid", wr_valid, 0);
      step(4'd0, 1'b1, 1'b0);
      chk("t1_valid", wr_valid, 1);
      chk("t1_addr0", wr_addr, 0);
      push_n(4'd0, 3, 1'b1);
      chk("t1_one_word", n_deliv - d0, 1);
      chk("t1_fill0", fill, 0);
      chk("t1_align", align_err, 0);

      // exact 17 units from mixed sizes, then a 20-unit overshoot
      d0 = n_deliv;
      push_n(4'd1, 4, 1'b1);
      push_n(4'd4, 1, 1'b1);
      push_n(4'd0, 3, 1'b1);
      chk("t2_one_word", n_deliv - d0, 1);
      chk("t2_no_align", align_err, 0);
      d0 = n_deliv;
      push_n(4'd1, 5, 1'b1);
      push_n(4'd0, 4, 1'b1);
      chk("t2_ovs_word", n_deliv - d0, 1);
      chk("t2_fill3", fill, 3);
      chk("t2_align", align_err, 1);

      // stalled port: third word lost, buffered ones drain in order
      step(4'd0, 1'b1, 1'b1);
      d0 = n_deliv;
      push_n(4'd4, 51, 1'b0);
      push_n(4'd0, 2, 1'b0);
      chk("t3_overflow", overflow, 1);
      chk("t3_head_addr0", wr_addr, 0);
      push_n(4'd0, 4, 1'b1);
      chk("t3_two_words", n_deliv - d0, 2);
      chk("t3_last_addr1", last_addr, 1);
      push_n(4'd4, 17, 1'b1);
      push_n(4'd0, 3, 1'b1);
      chk("t3_next_addr2", last_addr, 2);

      // full buffer, capture and pop on the same edge
      step(4'd0, 1'b0, 1'b1);
      d0 = n_deliv;
      push_n(4'd4, 51, 1'b0);
      step(4'd0, 1'b1, 1'b0);
      chk("t4_no_overflow", overflow, 0);
      push_n(4'd0, 4, 1'b1);
      chk("t4_three_words", n_deliv - d0, 3);
      chk("t4_last_addr2", last_addr, 2);

      // address wrap with a 4-bit counter
      step(4'd0, 1'b1, 1'b1);
      d0 = n_deliv;
      push_n(4'd4, 18 * 17, 1'b1);
      push_n(4'd0, 4, 1'b1);
      chk("t5_18_words", n_deliv - d0, 18);
      chk("t5_wrap_addr1", last_addr, 1);
      chk("t5_no_overflow", overflow, 0);

      // reset with a partial fill and a word pending
      step(4'd0, 1'b1, 1'b1);
      push_n(4'd4, 26, 1'b0);
      chk("t6_fill9", fill, 9);
      chk("t6_valid", wr_valid, 1);
      step(4'd0, 1'b0, 1'b1);
      chk("t6_fill0", fill, 0);
      chk("t6_valid0", wr_valid, 0);
      chk("t6_addr0", wr_addr, 0);
      chk("t6_data0", wr_data, 0);
      chk("t6_flags", {align_err, overflow}, 0);
      d0 = n_deliv;
      push_n(4'd4, 17, 1'b1);
      push_n(4'd0, 3, 1'b1);
      chk("t6_one_word", n_deliv - d0, 1);
      chk("t6_addr_restart", last_addr, 0);

      // random lengths, backpressure and occasional reset
      for (int i = 0; i < 800; i++) begin
         step(4'($urandom_range(0, 7)), $urandom_range(0, 9) < 7, $urandom_range(0, 99) == 0);
      end
      push_n(4'd0, 4, 1'b1);
      chk("drain_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
